// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH-channel programmable 50%-duty clock divider with a write/ack config port.
// Build option CLKDIV_TICK_EN adds one-cycle tick strobes on every clkOut toggle.
module clk_div_multi #(
    parameter int NCH         = 4,
    parameter int W           = 26,
    parameter int DEFAULT_DIV = 25000000,
    parameter int CHW         = 4
) (
    input  logic             clkIn,
    input  logic             rstIn_n,
    input  logic [NCH-1:0]   en,
    input  logic             cfg_wr,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [W-1:0]     cfg_div,
    input  logic             cfg_restart,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic [NCH-1:0]   clkOut,
    output logic [NCH-1:0]   tick
);

    logic chValid;

    // Zero-extend by one bit so NCH == 2**CHW compares correctly.
    assign chValid = ({1'b0, cfg_ch} < (CHW+1)'(NCH));

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clkIn or negedge rstIn_n) begin
        if (!rstIn_n) begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= cfg_wr;
            cfg_err <= cfg_wr && !chValid;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : gCh
        logic [W-1:0] cnt, cntNext;
        logic [W-1:0] act, actNext;
        logic [W-1:0] pend, pendNext;
        logic         pendVld, pendVldNext;
        logic         outQ, outNext;
        logic         wrHit, restartHit, terminal;

        assign wrHit      = cfg_wr && chValid && (cfg_ch == CHW'(i));
        assign restartHit = wrHit && cfg_restart;
        assign terminal   = en[i] && (act != '0) && (cnt == act - W'(1));

        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        always_comb begin
            cntNext     = cnt;
            actNext     = act;
            pendNext    = pend;
            pendVldNext = pendVld;
            outNext     = outQ;

            if (!en[i]) begin
                cntNext = '0;
                outNext = 1'b0;
            end else if (act == '0) begin
                cntNext = '0;
            end else if (terminal) begin
                cntNext = '0;
                outNext = ~outQ;
                if (pendVld) begin
                    actNext     = pend;
                    pendVldNext = 1'b0;
                end
            end else begin
                cntNext = cnt + W'(1);
            end

            // A write overrides the counting result; restart re-phases the channel.
            if (restartHit) begin
                actNext     = cfg_div;
                cntNext     = '0;
                outNext     = 1'b0;
                pendVldNext = 1'b0;
            end else if (wrHit) begin
                pendNext    = cfg_div;
                pendVldNext = 1'b1;
            end
        end

        // NOTE: divisor registers are per-channel flops, so they take their default on async reset.
        always_ff @(posedge clkIn or negedge rstIn_n) begin
            if (!rstIn_n) begin
                cnt     <= '0;
                act     <= W'(DEFAULT_DIV);
                pend    <= W'(DEFAULT_DIV);
                pendVld <= 1'b0;
                outQ    <= 1'b0;
            end else begin
                cnt     <= cntNext;
                act     <= actNext;
                pend    <= pendNext;
                pendVld <= pendVldNext;
                outQ    <= outNext;
            end
        end

        assign clkOut[i] = outQ;

`ifdef CLKDIV_TICK_EN
        logic tickQ;

        always_ff @(posedge clkIn or negedge rstIn_n) begin
            if (!rstIn_n) tickQ <= 1'b0;
            else          tickQ <= terminal && !restartHit;
        end

        assign tick[i] = tickQ;
`else
        assign tick[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: due-time behavioural model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_clk_div_multi;

    localparam int NCH = 4;
    localparam int W   = 26;
    localparam int DEF = 5;
    localparam int CHW = 4;

    logic             clkIn = 1'b0;
    logic             rstIn_n;
    logic [NCH-1:0]   en;
    logic             cfg_wr;
    logic [CHW-1:0]   cfg_ch;
    logic [W-1:0]     cfg_div;
    logic             cfg_restart;
    logic             cfg_ack;
    logic             cfg_err;
    logic [NCH-1:0]   clkOut;
    logic [NCH-1:0]   tick;

    int nChecks = 0;
    int nFail   = 0;

    clk_div_multi #(.NCH(NCH), .W(W), .DEFAULT_DIV(DEF), .CHW(CHW)) dut (
        .clkIn      (clkIn),
        .rstIn_n    (rstIn_n),
        .en         (en),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_restart(cfg_restart),
        .cfg_ack    (cfg_ack),
        .cfg_err    (cfg_err),
        .clkOut     (clkOut),
        .tick       (tick)
    );

    always #5 clkIn = ~clkIn;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // Model: each channel remembers the absolute edge index of its next toggle.
    logic [NCH-1:0] mOut  = '0;
    logic [NCH-1:0] mTick = '0;
    logic           mAck  = 1'b0;
    logic           mErr  = 1'b0;
    int             mDiv [NCH];
    int             mPend[NCH];
    bit             mPv  [NCH];
    longint         mDue [NCH];
    longint         e = 0;

    always @(posedge clkIn or negedge rstIn_n) begin : model
        bit hit;
        if (!rstIn_n) begin
            mAck  = 1'b0;
            mErr  = 1'b0;
            mOut  = '0;
            mTick = '0;
            for (int i = 0; i < NCH; i++) begin
                mDiv[i]  = DEF;
                mPend[i] = DEF;
                mPv[i]   = 1'b0;
                mDue[i]  = e + DEF;
            end
        end else begin
            e++;
            mAck = cfg_wr;
            mErr = cfg_wr && (int'(cfg_ch) >= NCH);
            for (int i = 0; i < NCH; i++) begin
                hit = cfg_wr && (int'(cfg_ch) == i);
                mTick[i] = 1'b0;
                if (hit && cfg_restart) begin
                    mDiv[i] = int'(cfg_div);
                    mPv[i]  = 1'b0;
                    mOut[i] = 1'b0;
                    mDue[i] = e + mDiv[i];
                end else begin
                    if (!en[i] || mDiv[i] == 0) begin
                        if (!en[i]) mOut[i] = 1'b0;
                        mDue[i] = e + mDiv[i];
                    end else if (e == mDue[i]) begin
                        mOut[i]  = ~mOut[i];
                        mTick[i] = 1'b1;
                        if (mPv[i]) begin
                            mDiv[i] = mPend[i];
                            mPv[i]  = 1'b0;
                        end
                        mDue[i] = e + mDiv[i];
                    end
                    if (hit) begin
                        mPend[i] = int'(cfg_div);
                        mPv[i]   = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clkIn) begin
        check("model_clkOut", 32'(clkOut), 32'(mOut));
`ifdef CLKDIV_TICK_EN
        check("model_tick", 32'(tick), 32'(mTick));
`else
        check("model_tick", 32'(tick), 32'd0);
`endif
        check("model_ack", 32'(cfg_ack), 32'(mAck));
        check("model_err", 32'(cfg_err), 32'(mErr));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clkIn);
    endtask

    task automatic wr(input int ch, input int div, input bit rs);
        cfg_wr      = 1'b1;
        cfg_ch      = CHW'(ch);
        cfg_div     = W'(div);
        cfg_restart = rs;
        @(negedge clkIn);
        cfg_wr      = 1'b0;
        cfg_restart = 1'b0;
    endtask

    initial begin
        en          = '0;
        cfg_wr      = 1'b0;
        cfg_ch      = '0;
        cfg_div     = '0;
        cfg_restart = 1'b0;
        rstIn_n     = 1'b1;
        #2 rstIn_n  = 1'b0;
        step(2);
        check("rst_clkOut", 32'(clkOut), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_ack", 32'(cfg_ack), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);

        // Channel 0 on the default divisor of 5.
        rstIn_n = 1'b1;
        en      = 4'b0001;
        step(4);
        check("ch0_c4", 32'(clkOut), 32'd0);
        step(1);
        check("ch0_c5", 32'(clkOut), 32'b0001);
`ifdef CLKDIV_TICK_EN
        check("ch0_tick_c5", 32'(tick), 32'b0001);
`else
        check("ch0_tick_c5", 32'(tick), 32'd0);
`endif
        step(4);
        check("ch0_c9", 32'(clkOut), 32'b0001);
        step(1);
        check("ch0_c10", 32'(clkOut), 32'd0);
        step(5);
        check("ch0_c15", 32'(clkOut), 32'b0001);

        // Channel 1: D=3, then a deferred change to 7.
        en = 4'b0011;
        wr(1, 3, 1'b1);
        check("ch1_ack", 32'(cfg_ack), 32'd1);
        check("ch1_restart", 32'(clkOut[1]), 32'd0);
        step(2);
        check("ch1_w2", 32'(clkOut[1]), 32'd0);
        step(1);
        check("ch1_w3", 32'(clkOut[1]), 32'd1);
        wr(1, 7, 1'b0);
        check("ch1_pend_ack", 32'(cfg_ack), 32'd1);
        step(1);
        check("ch1_ack_drop", 32'(cfg_ack), 32'd0);
        check("ch1_w5", 32'(clkOut[1]), 32'd1);
        step(1);
        check("ch1_w6", 32'(clkOut[1]), 32'd0);
        step(6);
        check("ch1_w12", 32'(clkOut[1]), 32'd0);
        step(1);
        check("ch1_w13", 32'(clkOut[1]), 32'd1);
        step(6);
        check("ch1_w19", 32'(clkOut[1]), 32'd1);
        step(1);
        check("ch1_w20", 32'(clkOut[1]), 32'd0);

        // Channel 2: D=100, restart to D=2 at count 40.
        en = 4'b0111;
        wr(2, 100, 1'b1);
        step(40);
        wr(2, 2, 1'b1);
        check("ch2_restart", 32'(clkOut[2]), 32'd0);
        step(1);
        check("ch2_r1", 32'(clkOut[2]), 32'd0);
        step(1);
        check("ch2_r2", 32'(clkOut[2]), 32'd1);
        step(1);
        check("ch2_r3", 32'(clkOut[2]), 32'd1);
        step(1);
        check("ch2_r4", 32'(clkOut[2]), 32'd0);

        // Out-of-range channel.
        wr(9, 123, 1'b1);
        check("bad_ack", 32'(cfg_ack), 32'd1);
        check("bad_err", 32'(cfg_err), 32'd1);
        step(1);
        check("bad_ack_drop", 32'(cfg_ack), 32'd0);
        check("bad_err_drop", 32'(cfg_err), 32'd0);

        // Channel 3: freeze high via pending D=0, then restart with D=4.
        en = 4'b1111;
        wr(3, 3, 1'b1);
        wr(3, 0, 1'b0);
        step(1);
        check("ch3_w2", 32'(clkOut[3]), 32'd0);
        step(1);
        check("ch3_w3", 32'(clkOut[3]), 32'd1);
        step(20);
        check("ch3_frozen", 32'(clkOut[3]), 32'd1);
        wr(3, 4, 1'b1);
        check("ch3_restart", 32'(clkOut[3]), 32'd0);
        step(3);
        check("ch3_r3", 32'(clkOut[3]), 32'd0);
        step(1);
        check("ch3_r4", 32'(clkOut[3]), 32'd1);
        step(3);
        check("ch3_r7", 32'(clkOut[3]), 32'd1);
        step(1);
        check("ch3_r8", 32'(clkOut[3]), 32'd0);

        // Asynchronous reset between edges.
        step(3);
        #2 rstIn_n = 1'b0;
        #1;
        check("arst_clkOut", 32'(clkOut), 32'd0);
        check("arst_tick", 32'(tick), 32'd0);
        check("arst_ack", 32'(cfg_ack), 32'd0);
        check("arst_err", 32'(cfg_err), 32'd0);
        @(negedge clkIn);
        rstIn_n = 1'b1;
        step(4);
        check("post_c4", 32'(clkOut), 32'd0);
        step(1);
        check("post_c5", 32'(clkOut), 32'b1111);
        step(5);
        check("post_c10", 32'(clkOut), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised, multi-channel programmable clock divider for DE0 designs driven by the 50 MHz board clock.
- Each of NCH channels produces a 50%-duty square wave at f_clkIn / (2*DIV) and, optionally, a one-cycle strobe at each output edge.
- Divisors are runtime-programmable through a simple write/ack port, so one instance serves LCD timing, blink rates and scan clocks.
- Each channel's output is a registered, glitch-free enable-domain signal.

Parameters:
- NCH, 4, number of independent channels (1..16)
- W, 26, width of each divisor and counter
- DEFAULT_DIV, 25000000, reset divisor loaded into every channel (1 Hz at 50 MHz)
- CHW, 4, width of cfg_ch; must satisfy 2^CHW >= NCH

Ports:
- clkIn  input  1  system clock, 50 MHz
- rstIn_n  input  1  asynchronous active-low reset
- en  input  NCH  per-channel run enable
- cfg_wr  input  1  write strobe, one cycle
- cfg_ch  input  CHW  target channel of write
- cfg_div  input  W  new half-period divisor
- cfg_restart  input  1  sampled with cfg_wr; 1 = apply immediately and re-phase
- cfg_ack  output  1  one-cycle acknowledge of a write
- cfg_err  output  1  one-cycle flag, write rejected
- clkOut  output  NCH  divided square waves
- tick  output  NCH  one-cycle strobe per clkOut toggle (see Optional Feature)

Behaviour:
- Reset (async, rstIn_n=0):
  - All counters = 0, clkOut = 0, tick = 0, cfg_ack = 0, cfg_err = 0.
  - Active and pending divisor = DEFAULT_DIV for every channel; pending-valid = 0.
- Per-channel counter, when en[i]=1 and active div D >= 1:
  - Counts 0..D-1.
  - At count D-1: counter -> 0, clkOut[i] toggles, tick[i]=1 for that cycle.
  - Output period = 2*D clkIn cycles. D=1 gives f/2.
- D = 0: channel frozen; counter held at 0, clkOut[i] held at its current value, no ticks.
- en[i]=0: counter held at 0, clkOut[i] forced 0 on next edge, no ticks. On re-enable the first toggle occurs D cycles after en rises (clkOut rises at cycle D).
- Config write (cfg_wr=1 at edge N):
  - Handshake: cfg_ack=1 at edge N+1, exactly one cycle. No busy state; back-to-back writes are accepted every cycle.
  - cfg_ch >= NCH: no state change; cfg_ack=1 and cfg_err=1 at N+1.
  - cfg_restart=0: cfg_div is stored as pending. It becomes active at the channel's next terminal count, in the same cycle as the toggle, so no shortened half-period occurs. A second pending write before then overwrites the first.
  - cfg_restart=1: active div = cfg_div at N+1, counter = 0, clkOut[i] = 0, any pending value is discarded.
- Simultaneous events:
  - Write to a channel at its terminal count, restart=0: the toggle uses the old divisor; the new value goes pending and is applied at the following terminal count.
  - en[i]=0 with a write in the same cycle: the write is still stored (active if restart, else pending).
- Channels are fully independent. There is no cross-channel phase relation except after a common reset or a restart.
- Outputs are registered. Zero combinational paths from inputs to outputs.

Optional Feature:
- Macro: CLKDIV_TICK_EN.
- Defined: the tick port is driven as described above.
- Undefined: tick is tied to constant 0, and its logic is removed from the build. All other behaviour is identical.

Test Plan:
- Reset then en=4'b0001, DEFAULT_DIV overridden to 5 -> clkOut[0] rises at cycle 5, falls at 10, period 10; tick[0] pulses at cycles 5, 10, 15; other channels stay 0.
- Channel 1 running D=3, write cfg_ch=1 cfg_div=7 restart=0 mid-half-period -> current half-period completes at 3 cycles, following half-periods are 7; cfg_ack pulses once, one cycle after the write.
- Channel 2 running D=100, write cfg_div=2 restart=1 at count 40 -> clkOut[2]=0 and counter=0 next cycle; toggles every 2 cycles thereafter.
- Write cfg_ch=9 with NCH=4 -> cfg_ack=1 and cfg_err=1 for one cycle; all divisors unchanged.
- Write D=0 to channel 3 while clkOut[3]=1 -> output frozen high, no ticks. Then write D=4 restart=1 -> output goes 0, then toggles every 4 cycles.
- Assert rstIn_n low asynchronously mid-count, between clkIn edges -> all outputs 0 immediately. After release, every channel resumes with DEFAULT_DIV.
